// File: rtl/ext_bus_target.sv
// ext_bus_target: responder for the external multiplexed 16-bit AD bus.
// Turns ALE0/ALE1 address phases and OE_N/WE_N strobes into single-beat
// requests on an internal valid/ready bus, and drives read data onto AD.
// Optional feature macro: EXTBUS_SYNC_EN. When it is defined, every bus input
// passes through a SYNC_STAGES-deep synchronizer. When it is undefined, a single
// input register is used and the master must be synchronous to CLK.
module ext_bus_target #(
  parameter int SYNC_STAGES = 2
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic [15:0] AD_IN,
  output logic [15:0] AD_OUT,
  output logic        AD_OE,
  input  logic        ALE0,
  input  logic        ALE1,
  input  logic        OE_N,
  input  logic        WE_N,
  input  logic        BHE_N,
  output logic        req_valid,
  input  logic        req_ready,
  output logic        req_we,
  output logic [31:0] req_addr,
  output logic [15:0] req_wdata,
  output logic [1:0]  req_be,
  input  logic        rsp_valid,
  input  logic [15:0] rsp_rdata,
  output logic        err
);

`ifdef EXTBUS_SYNC_EN
  localparam int S = SYNC_STAGES;
`else
  localparam int S = 1;
`endif

  // Reject illegal synchronizer depths at elaboration.
  if (SYNC_STAGES != 2 && SYNC_STAGES != 3) begin : g_bad_sync_stages
    $error("ext_bus_target: SYNC_STAGES must be 2 or 3");
  end

  // Packed pin bundle: {ALE0, ALE1, OE_N, WE_N, BHE_N, AD}.
  localparam int W = 21;
  localparam logic [W-1:0] PINS_IDLE = {1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 16'h0000};

  typedef enum logic [2:0] {
    IDLE, WR_REQ, RD_REQ, RD_WAIT, RD_DRIVE, RD_DRAIN
  } state_t;

  logic [W-1:0] pins_raw;
  logic [W-1:0] pipe [S];
  logic         s_ale0, s_ale1, s_oe_n, s_we_n, s_bhe_n;
  logic [15:0]  s_ad;
  logic         p_ale0, p_ale1, p_oe_n, p_we_n;
  logic [15:0]  p_ad;
  logic         ale0_fall, ale1_fall, we_rise, we_fall, oe_rise, oe_fall;
  logic [31:0]  addr_q;
  logic [15:0]  wcap_data;
  logic         wcap_bhe_n;
  state_t       state;
  logic         abort_q;
  logic         rd_state;
  logic         stray_strobe;

  assign pins_raw = {ALE0, ALE1, OE_N, WE_N, BHE_N, AD_IN};

  // Sample pipeline: every bus input goes through the same number of flops.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      for (int i = 0; i < S; i++) pipe[i] <= PINS_IDLE;
    end else begin
      pipe[0] <= pins_raw;
      for (int i = 1; i < S; i++) pipe[i] <= pipe[i-1];
    end
  end

  assign s_ale0  = pipe[S-1][20];
  assign s_ale1  = pipe[S-1][19];
  assign s_oe_n  = pipe[S-1][18];
  assign s_we_n  = pipe[S-1][17];
  assign s_bhe_n = pipe[S-1][16];
  assign s_ad    = pipe[S-1][15:0];

  // Previous value of the last pipeline stage, used for edge detection.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      p_ale0 <= 1'b0;
      p_ale1 <= 1'b0;
      p_oe_n <= 1'b1;
      p_we_n <= 1'b1;
      p_ad   <= 16'h0000;
    end else begin
      p_ale0 <= s_ale0;
      p_ale1 <= s_ale1;
      p_oe_n <= s_oe_n;
      p_we_n <= s_we_n;
      p_ad   <= s_ad;
    end
  end

  assign ale0_fall = p_ale0 & ~s_ale0;
  assign ale1_fall = p_ale1 & ~s_ale1;
  assign we_rise   = ~p_we_n & s_we_n;
  assign we_fall   = p_we_n & ~s_we_n;
  assign oe_rise   = ~p_oe_n & s_oe_n;
  assign oe_fall   = p_oe_n & ~s_oe_n;

  // Address halves latch the AD value seen with the last high ALE sample.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      addr_q <= 32'h0;
    end else begin
      if (ale0_fall) addr_q[15:0]  <= p_ad;
      if (ale1_fall) addr_q[31:16] <= p_ad;
    end
  end

  // Write data and byte-high enable track AD while the write strobe is low.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      wcap_data  <= 16'h0000;
      wcap_bhe_n <= 1'b1;
    end else if (!s_we_n) begin
      wcap_data  <= s_ad;
      wcap_bhe_n <= s_bhe_n;
    end
  end

  // An OE_N rise is expected in read states; every other strobe edge outside
  // IDLE is a protocol violation.
  assign rd_state     = (state == RD_REQ) || (state == RD_WAIT) ||
                        (state == RD_DRIVE) || (state == RD_DRAIN);
  assign stray_strobe = (state != IDLE) &&
                        (we_rise || we_fall || oe_fall || (oe_rise && !rd_state));

  // Bus-cycle state machine with registered request, AD drive and error outputs.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state     <= IDLE;
      abort_q   <= 1'b0;
      req_valid <= 1'b0;
      req_we    <= 1'b0;
      req_addr  <= 32'h0;
      req_wdata <= 16'h0000;
      req_be    <= 2'b00;
      AD_OUT    <= 16'h0000;
      AD_OE     <= 1'b0;
      err       <= 1'b0;
    end else begin
      if (stray_strobe) err <= 1'b1;
      case (state)
        IDLE: begin
          if (we_rise) begin
            state     <= WR_REQ;
            req_valid <= 1'b1;
            req_we    <= 1'b1;
            req_addr  <= addr_q;
            req_wdata <= wcap_data;
            req_be    <= {~wcap_bhe_n, ~addr_q[0]};
            if (oe_fall) err <= 1'b1;
          end else if (oe_fall) begin
            state     <= RD_REQ;
            req_valid <= 1'b1;
            req_we    <= 1'b0;
            req_addr  <= addr_q;
            req_be    <= {~s_bhe_n, ~addr_q[0]};
            abort_q   <= 1'b0;
          end
        end
        WR_REQ: begin
          if (req_ready) begin
            req_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        RD_REQ: begin
          if (oe_rise) begin
            abort_q <= 1'b1;
            err     <= 1'b1;
          end
          if (req_ready) begin
            req_valid <= 1'b0;
            state     <= RD_WAIT;
          end
        end
        RD_WAIT: begin
          if (oe_rise) begin
            abort_q <= 1'b1;
            err     <= 1'b1;
          end
          if (rsp_valid) begin
            AD_OUT <= rsp_rdata;
            if (abort_q || oe_rise) begin
              state <= RD_DRAIN;
            end else if (!s_oe_n) begin
              state <= RD_DRIVE;
              AD_OE <= 1'b1;
            end else begin
              state <= IDLE;
            end
          end
        end
        RD_DRIVE: begin
          if (s_oe_n) begin
            AD_OE <= 1'b0;
            state <= IDLE;
          end
        end
        RD_DRAIN: begin
          abort_q <= 1'b0;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ext_bus_target.sv
// tb_ext_bus_target: randomized self-checking bench for ext_bus_target.
// Acts as a synchronous bus master and internal responder; expected values come
// from a transaction-level model (address, data, byte enables, sticky error,
// pin-to-output latency S+1). EXTBUS_SYNC_EN selects the synchronizer build.
module tb_ext_bus_target #(
  parameter int SYNC = 2
);

`ifdef EXTBUS_SYNC_EN
  localparam int S = SYNC;
`else
  localparam int S = 1;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] ad_in = 16'h0000;
  logic [15:0] ad_out;
  logic        ad_oe;
  logic        ale0 = 1'b0, ale1 = 1'b0, oe_n = 1'b1, we_n = 1'b1, bhe_n = 1'b1;
  logic        req_valid, req_we, err;
  logic        req_ready = 1'b0;
  logic [31:0] req_addr;
  logic [15:0] req_wdata;
  logic [1:0]  req_be;
  logic        rsp_valid = 1'b0;
  logic [15:0] rsp_rdata = 16'h0000;

  int          vectors = 0;
  int          miscompares = 0;
  logic [31:0] model_addr = 32'h0;
  logic        model_err = 1'b0;

  ext_bus_target #(.SYNC_STAGES(SYNC)) dut (
    .CLK(clk), .RST_N(rst_n), .AD_IN(ad_in), .AD_OUT(ad_out), .AD_OE(ad_oe),
    .ALE0(ale0), .ALE1(ale1), .OE_N(oe_n), .WE_N(we_n), .BHE_N(bhe_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .err(err)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got still running, want finished");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic nedge(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Two address phases; the model address follows the pin-level values.
  task automatic latch_addr(input logic [31:0] a);
    ad_in = a[15:0]; ale0 = 1'b1; nedge(1);
    ale0 = 1'b0; nedge(S + 1);
    ad_in = a[31:16]; ale1 = 1'b1; nedge(1);
    ale1 = 1'b0; nedge(S + 1);
    model_addr = a;
  endtask

  // Count rising edges until req_valid appears; -1 if it never does.
  task automatic wait_req(output int lat);
    lat = -1;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (req_valid) begin
        lat = k;
        break;
      end
    end
  endtask

  task automatic do_write(input logic [15:0] d, input logic bhe, output int lat);
    ad_in = d; bhe_n = bhe; we_n = 1'b0; nedge(2);
    we_n = 1'b1;
    wait_req(lat);
  endtask

  task automatic accept_req();
    req_ready = 1'b1; nedge(1); req_ready = 1'b0;
  endtask

  task automatic pulse_rsp(input logic [15:0] d);
    rsp_valid = 1'b1; rsp_rdata = d; nedge(1);
    rsp_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; nedge(3);
    vectors++; if (ad_oe !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_ad_oe: got %b want 0", ad_oe); end
    vectors++; if (ad_out !== 16'h0) begin miscompares++; $display("[TB] FAIL reset_ad_out: got %h want 0000", ad_out); end
    vectors++; if (req_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_req_valid: got %b want 0", req_valid); end
    vectors++; if (req_we !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_req_we: got %b want 0", req_we); end
    vectors++; if (req_addr !== 32'h0) begin miscompares++; $display("[TB] FAIL reset_req_addr: got %h want 0", req_addr); end
    vectors++; if (req_wdata !== 16'h0) begin miscompares++; $display("[TB] FAIL reset_req_wdata: got %h want 0", req_wdata); end
    vectors++; if (req_be !== 2'b00) begin miscompares++; $display("[TB] FAIL reset_req_be: got %b want 00", req_be); end
    vectors++; if (err !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_err: got %b want 0", err); end
    rst_n = 1'b1; nedge(3);
    vectors++; if (req_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL post_reset_idle: got %b want 0", req_valid); end
  endtask

  task automatic test_write();
    logic [31:0] a;
    logic [15:0] d;
    logic        bhe;
    logic [1:0]  be;
    int          lat;
    for (int it = 0; it < 4; it++) begin
      if (it == 0) begin
        a = 32'h0000_1234; d = 16'hBEEF; bhe = 1'b0;
      end else begin
        a = $urandom; d = 16'($urandom); bhe = 1'($urandom);
      end
      be = {~bhe, ~a[0]};
      latch_addr(a);
      do_write(d, bhe, lat);
      vectors++; if (lat !== S + 1) begin miscompares++; $display("[TB] FAIL write_latency: got %0d want %0d", lat, S + 1); end
      vectors++; if (req_we !== 1'b1) begin miscompares++; $display("[TB] FAIL write_we: got %b want 1", req_we); end
      vectors++; if (req_addr !== model_addr) begin miscompares++; $display("[TB] FAIL write_addr: got %h want %h", req_addr, model_addr); end
      vectors++; if (req_wdata !== d) begin miscompares++; $display("[TB] FAIL write_wdata: got %h want %h", req_wdata, d); end
      vectors++; if (req_be !== be) begin miscompares++; $display("[TB] FAIL write_be: got %b want %b", req_be, be); end
      for (int c = 0; c < 4; c++) begin
        nedge(1);
        vectors++;
        if ({req_valid, req_we, req_addr, req_wdata, req_be} !== {1'b1, 1'b1, model_addr, d, be}) begin
          miscompares++;
          $display("[TB] FAIL write_hold: got %b/%h/%h/%b want 1/%h/%h/%b", req_valid, req_addr, req_wdata, req_be, model_addr, d, be);
        end
      end
      accept_req();
      vectors++; if (req_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL write_accept: got %b want 0", req_valid); end
      vectors++; if (err !== model_err) begin miscompares++; $display("[TB] FAIL write_err: got %b want %b", err, model_err); end
      nedge(2);
    end
  endtask

  task automatic test_read();
    logic [31:0] a;
    logic [15:0] rd;
    logic        bhe;
    int          lat;
    for (int it = 0; it < 4; it++) begin
      if (it == 0) begin
        a = 32'h0002_0010; rd = 16'hCAFE; bhe = 1'b0;
      end else begin
        a = $urandom; rd = 16'($urandom); bhe = 1'($urandom);
      end
      latch_addr(a);
      bhe_n = bhe; oe_n = 1'b0;
      wait_req(lat);
      vectors++; if (lat !== S + 1) begin miscompares++; $display("[TB] FAIL read_latency: got %0d want %0d", lat, S + 1); end
      vectors++; if (req_we !== 1'b0) begin miscompares++; $display("[TB] FAIL read_we: got %b want 0", req_we); end
      vectors++; if (req_addr !== model_addr) begin miscompares++; $display("[TB] FAIL read_addr: got %h want %h", req_addr, model_addr); end
      vectors++; if (req_be !== {~bhe, ~a[0]}) begin miscompares++; $display("[TB] FAIL read_be: got %b want %b", req_be, {~bhe, ~a[0]}); end
      nedge($urandom_range(0, 2));
      accept_req();
      vectors++; if (req_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL read_accept: got %b want 0", req_valid); end
      nedge(2);
      vectors++; if (ad_oe !== 1'b0) begin miscompares++; $display("[TB] FAIL read_oe_early: got %b want 0", ad_oe); end
      pulse_rsp(rd);
      vectors++; if (ad_oe !== 1'b1) begin miscompares++; $display("[TB] FAIL read_ad_oe: got %b want 1", ad_oe); end
      vectors++; if (ad_out !== rd) begin miscompares++; $display("[TB] FAIL read_ad_out: got %h want %h", ad_out, rd); end
      nedge(2);
      oe_n = 1'b1;
      lat = -1;
      for (int k = 1; k <= 20; k++) begin
        @(negedge clk);
        if (!ad_oe) begin
          lat = k;
          break;
        end
      end
      vectors++; if (lat !== S + 1) begin miscompares++; $display("[TB] FAIL read_turnaround: got %0d want %0d", lat, S + 1); end
      vectors++; if (err !== model_err) begin miscompares++; $display("[TB] FAIL read_err: got %b want %b", err, model_err); end
      nedge(2);
    end
  endtask

  task automatic test_aborted_read();
    logic        seen_oe;
    logic [15:0] d;
    int          lat;
    latch_addr($urandom);
    seen_oe = 1'b0;
    oe_n = 1'b0; nedge(1);
    oe_n = 1'b1;
    wait_req(lat);
    vectors++; if (lat !== S) begin miscompares++; $display("[TB] FAIL abort_req_latency: got %0d want %0d", lat, S); end
    model_err = 1'b1;
    accept_req();
    for (int k = 0; k < 6; k++) begin
      nedge(1);
      seen_oe |= ad_oe;
    end
    pulse_rsp(16'($urandom));
    for (int k = 0; k < 4; k++) begin
      seen_oe |= ad_oe;
      nedge(1);
    end
    vectors++; if (seen_oe !== 1'b0) begin miscompares++; $display("[TB] FAIL abort_ad_oe: got %b want 0", seen_oe); end
    vectors++; if (err !== 1'b1) begin miscompares++; $display("[TB] FAIL abort_err: got %b want 1", err); end
    vectors++; if (req_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL abort_no_req: got %b want 0", req_valid); end
    d = 16'($urandom);
    latch_addr($urandom);
    do_write(d, 1'b1, lat);
    vectors++; if (lat !== S + 1) begin miscompares++; $display("[TB] FAIL abort_next_latency: got %0d want %0d", lat, S + 1); end
    vectors++; if ({req_we, req_addr, req_wdata} !== {1'b1, model_addr, d}) begin miscompares++; $display("[TB] FAIL abort_next_write: got %b/%h/%h want 1/%h/%h", req_we, req_addr, req_wdata, model_addr, d); end
    accept_req();
    nedge(2);
  endtask

  task automatic test_reset_mid_drive();
    int lat;
    latch_addr($urandom);
    oe_n = 1'b0;
    wait_req(lat);
    accept_req();
    nedge(1);
    pulse_rsp(16'($urandom));
    vectors++; if (ad_oe !== 1'b1) begin miscompares++; $display("[TB] FAIL drive_before_reset: got %b want 1", ad_oe); end
    #2 rst_n = 1'b0;
    #1;
    vectors++; if (ad_oe !== 1'b0) begin miscompares++; $display("[TB] FAIL async_reset_ad_oe: got %b want 0", ad_oe); end
    vectors++; if (req_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL async_reset_req_valid: got %b want 0", req_valid); end
    vectors++; if (err !== 1'b0) begin miscompares++; $display("[TB] FAIL async_reset_err: got %b want 0", err); end
    vectors++; if (ad_out !== 16'h0) begin miscompares++; $display("[TB] FAIL async_reset_ad_out: got %h want 0000", ad_out); end
    model_err = 1'b0;
    oe_n = 1'b1;
    nedge(2);
    rst_n = 1'b1;
    nedge(2);
  endtask

  task automatic test_protocol_violation();
    logic [15:0] rd;
    int          lat;
    rd = 16'($urandom);
    latch_addr($urandom);
    oe_n = 1'b0;
    wait_req(lat);
    vectors++; if (req_addr !== model_addr) begin miscompares++; $display("[TB] FAIL viol_addr: got %h want %h", req_addr, model_addr); end
    accept_req();
    nedge(1);
    we_n = 1'b0; nedge(1);
    we_n = 1'b1; nedge(S + 3);
    model_err = 1'b1;
    vectors++; if (req_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL viol_no_write: got %b want 0", req_valid); end
    pulse_rsp(rd);
    vectors++; if (ad_oe !== 1'b1) begin miscompares++; $display("[TB] FAIL viol_ad_oe: got %b want 1", ad_oe); end
    vectors++; if (ad_out !== rd) begin miscompares++; $display("[TB] FAIL viol_ad_out: got %h want %h", ad_out, rd); end
    vectors++; if (err !== model_err) begin miscompares++; $display("[TB] FAIL viol_err: got %b want %b", err, model_err); end
    oe_n = 1'b1;
    nedge(S + 1);
    vectors++; if (ad_oe !== 1'b0) begin miscompares++; $display("[TB] FAIL viol_release: got %b want 0", ad_oe); end
    nedge(3);
    vectors++; if (req_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL viol_idle: got %b want 0", req_valid); end
  endtask

  task automatic test_reset_pending_req();
    int lat;
    latch_addr($urandom);
    do_write(16'($urandom), 1'b0, lat);
    vectors++; if (req_valid !== 1'b1) begin miscompares++; $display("[TB] FAIL pending_valid: got %b want 1", req_valid); end
    #2 rst_n = 1'b0;
    #1;
    vectors++; if (req_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL pending_dropped: got %b want 0", req_valid); end
    vectors++; if (err !== 1'b0) begin miscompares++; $display("[TB] FAIL pending_err: got %b want 0", err); end
    model_err = 1'b0;
    nedge(2);
    rst_n = 1'b1;
    nedge(2);
  endtask

  task automatic test_both_strobes();
    logic [15:0] d;
    int          lat;
    d = 16'($urandom);
    latch_addr($urandom);
    ad_in = d; bhe_n = 1'b1; we_n = 1'b0; nedge(2);
    we_n = 1'b1; oe_n = 1'b0;
    wait_req(lat);
    model_err = 1'b1;
    vectors++; if (lat !== S + 1) begin miscompares++; $display("[TB] FAIL both_latency: got %0d want %0d", lat, S + 1); end
    vectors++; if ({req_we, req_addr, req_wdata} !== {1'b1, model_addr, d}) begin miscompares++; $display("[TB] FAIL both_write_wins: got %b/%h/%h want 1/%h/%h", req_we, req_addr, req_wdata, model_addr, d); end
    vectors++; if (err !== model_err) begin miscompares++; $display("[TB] FAIL both_err: got %b want %b", err, model_err); end
    accept_req();
    oe_n = 1'b1;
    nedge(S + 3);
    vectors++; if ({req_valid, ad_oe} !== 2'b00) begin miscompares++; $display("[TB] FAIL both_idle: got %b want 00", {req_valid, ad_oe}); end
  endtask

  initial begin
    $display("[TB] ext_bus_target bench, S=%0d", S);
    test_reset();
    test_write();
    test_read();
    test_aborted_read();
    test_reset_mid_drive();
    test_protocol_violation();
    test_reset_pending_req();
    test_both_strobes();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
